// File: rtl/decode_stage.sv
// RV32 decode stage: combinational decode feeding a 2-entry skid buffer (EMPTY/ONE/FULL).
// Optional macro OSIRIS_DEC_MULDIV_EN makes OP with funct7=0000001 (M extension) legal.
module decode_stage #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instr,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_jump,
  output logic              o_branch,
  output logic              o_reg_write,
  output logic              o_mem_write,
  output logic              o_alu_src,
  output logic              o_addr_src,
  output logic              o_fence,
  output logic              o_muldiv,
  output logic              o_illegal,
  output logic [1:0]        o_result_src,
  output logic [2:0]        o_imm_src,
  output logic [3:0]        o_alu_ctrl,
  output logic [4:0]        o_rd,
  output logic [4:0]        o_rs1,
  output logic [4:0]        o_rs2,
  output logic [PC_W-1:0]   o_pc,
  output logic [CNT_W-1:0]  o_illegal_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef enum logic [4:0] {
    OPC_LOAD   = 5'b00000, OPC_FENCE = 5'b00011, OPC_OP_IMM = 5'b00100,
    OPC_AUIPC  = 5'b00101, OPC_STORE = 5'b01000, OPC_OP     = 5'b01100,
    OPC_LUI    = 5'b01101, OPC_BRANCH = 5'b11000, OPC_JALR  = 5'b11001,
    OPC_JAL    = 5'b11011, OPC_SYSTEM = 5'b11100
  } opcode_t;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010,
                         ALU_SLT = 4'b0011, ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101,
                         ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_OR = 4'b1000,
                         ALU_AND = 4'b1001;

  typedef struct packed {
    logic            jump, branch, reg_write, mem_write, alu_src, addr_src, fence, muldiv, illegal;
    logic [1:0]      result_src;
    logic [2:0]      imm_src;
    logic [3:0]      alu_ctrl;
    logic [4:0]      rd, rs1, rs2;
    logic [PC_W-1:0] pc;
  } bundle_t;

  state_t           state_q, state_nxt;
  bundle_t          dec, out_q, skid_q;
  logic             ready_q, in_xfer, out_xfer, load_out, load_skid, promote;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [3:0]       alu_f3;

  assign f3 = i_instr[14:12];
  assign f7 = i_instr[31:25];

  // Shared funct3 mapping for OP/OP-IMM; funct7[5] picks SRA here, SUB is applied for OP only.
  always_comb begin
    case (f3)
      3'b000:  alu_f3 = ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = f7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  end

  always_comb begin
    // NOTE: every field gets a default before the case so no path infers a latch.
    dec     = '0;
    dec.rd  = i_instr[11:7];
    dec.rs1 = i_instr[19:15];
    dec.rs2 = i_instr[24:20];
    dec.pc  = i_pc;
    case (opcode_t'(i_instr[6:2]))
      OPC_LUI:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.imm_src = 3'b100; end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.imm_src = 3'b100; dec.result_src = 2'b11;
      end
      OPC_JAL:   begin
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.imm_src = 3'b011; dec.result_src = 2'b10;
      end
      OPC_JALR:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.addr_src = 1'b1; end
      OPC_LOAD:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b01; end
      OPC_STORE: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.imm_src = 3'b001; end
      OPC_BRANCH: begin dec.branch = 1'b1; dec.imm_src = 3'b010; dec.alu_ctrl = ALU_SUB; end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = alu_f3;
        if ((f3 == 3'b001 && f7 != 7'b0000000) ||
            (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000))
          dec.illegal = 1'b1;
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.alu_ctrl = alu_f3;
        end else if (f7 == 7'b0100000) begin
          dec.alu_ctrl = (f3 == 3'b000) ? ALU_SUB : alu_f3;
          if (f3 != 3'b000 && f3 != 3'b101) dec.illegal = 1'b1;
`ifdef OSIRIS_DEC_MULDIV_EN
        end else if (f7 == 7'b0000001) begin
          dec.muldiv   = 1'b1;
          dec.alu_ctrl = {1'b0, f3};
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_SYSTEM: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
      OPC_FENCE:  dec.fence = 1'b1;
      default:    dec.illegal = 1'b1;
    endcase
    if (i_instr[1:0] != 2'b11) dec.illegal = 1'b1;
    if (dec.illegal) begin
      dec.reg_write = 1'b0; dec.mem_write = 1'b0; dec.jump   = 1'b0;
      dec.branch    = 1'b0; dec.fence     = 1'b0; dec.muldiv = 1'b0;
    end
  end

  assign in_xfer  = i_valid & ready_q & ~i_flush;
  assign out_xfer = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst_n) state_q <= EMPTY;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (i_flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (in_xfer) state_nxt = ONE;
        ONE:     if (in_xfer && !out_xfer) state_nxt = FULL;
                 else if (!in_xfer && out_xfer) state_nxt = EMPTY;
        FULL:    if (out_xfer) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    o_valid   = (state_q != EMPTY);
    load_out  = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    case (state_q)
      EMPTY:   load_out = in_xfer;
      ONE:     begin load_out = in_xfer & out_xfer; load_skid = in_xfer & ~out_xfer; end
      FULL:    promote = out_xfer & ~i_flush;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: the two bundle slots are plain flops, not a RAM, so they are reset to keep outputs defined.
    if (!i_rst_n) begin
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ready_q <= (state_nxt != FULL);
      if (load_out)      out_q  <= dec;
      else if (promote)  out_q  <= skid_q;
      if (load_skid)     skid_q <= dec;
      if (in_xfer && dec.illegal && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_ready       = ready_q;
  assign o_jump        = out_q.jump;
  assign o_branch      = out_q.branch;
  assign o_reg_write   = out_q.reg_write;
  assign o_mem_write   = out_q.mem_write;
  assign o_alu_src     = out_q.alu_src;
  assign o_addr_src    = out_q.addr_src;
  assign o_fence       = out_q.fence;
  assign o_muldiv      = out_q.muldiv;
  assign o_illegal     = out_q.illegal;
  assign o_result_src  = out_q.result_src;
  assign o_imm_src     = out_q.imm_src;
  assign o_alu_ctrl    = out_q.alu_ctrl;
  assign o_rd          = out_q.rd;
  assign o_rs1         = out_q.rs1;
  assign o_rs2         = out_q.rs2;
  assign o_pc          = out_q.pc;
  assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode table, skid buffer, flush, counter, reset.
module tb_decode_stage;
  localparam int PC_W = 32;
  localparam int CNT_W = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
  logic [31:0] i_instr = '0;
  logic [PC_W-1:0] i_pc = '0;
  logic o_ready, o_valid, o_jump, o_branch, o_reg_write, o_mem_write, o_alu_src, o_addr_src;
  logic o_fence, o_muldiv, o_illegal;
  logic [1:0] o_result_src;
  logic [2:0] o_imm_src;
  logic [3:0] o_alu_ctrl;
  logic [4:0] o_rd, o_rs1, o_rs2;
  logic [PC_W-1:0] o_pc;
  logic [CNT_W-1:0] o_illegal_cnt;

  // Second instance with a 2-bit counter for saturation.
  logic s_valid = 1'b0, s_flush = 1'b0, s_rdy_in = 1'b1;
  logic [31:0] s_instr = 32'hFFFF_FFFF;
  logic [PC_W-1:0] s_pc = '0;
  logic s_ready, s_ovalid, s_jump, s_branch, s_rw, s_mw, s_as, s_addr, s_fence, s_md, s_ill;
  logic [1:0] s_res;
  logic [2:0] s_imm;
  logic [3:0] s_alu;
  logic [4:0] s_rd, s_rs1, s_rs2;
  logic [PC_W-1:0] s_opc;
  logic [1:0] s_cnt;

  logic [17:0] ctl;
  assign ctl = {o_jump, o_branch, o_reg_write, o_mem_write, o_alu_src, o_addr_src, o_fence,
                o_muldiv, o_illegal, o_result_src, o_imm_src, o_alu_ctrl};

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
    .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_jump(o_jump),
    .o_branch(o_branch), .o_reg_write(o_reg_write), .o_mem_write(o_mem_write),
    .o_alu_src(o_alu_src), .o_addr_src(o_addr_src), .o_fence(o_fence), .o_muldiv(o_muldiv),
    .o_illegal(o_illegal), .o_result_src(o_result_src), .o_imm_src(o_imm_src),
    .o_alu_ctrl(o_alu_ctrl), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_pc(o_pc),
    .o_illegal_cnt(o_illegal_cnt)
  );

  decode_stage #(.PC_W(PC_W), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(s_ready), .i_instr(s_instr),
    .i_pc(s_pc), .i_flush(s_flush), .o_valid(s_ovalid), .i_ready(s_rdy_in), .o_jump(s_jump),
    .o_branch(s_branch), .o_reg_write(s_rw), .o_mem_write(s_mw), .o_alu_src(s_as),
    .o_addr_src(s_addr), .o_fence(s_fence), .o_muldiv(s_md), .o_illegal(s_ill),
    .o_result_src(s_res), .o_imm_src(s_imm), .o_alu_ctrl(s_alu), .o_rd(s_rd), .o_rs1(s_rs1),
    .o_rs2(s_rs2), .o_pc(s_opc), .o_illegal_cnt(s_cnt)
  );

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", o_valid); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", o_ready); end
    total++; if (o_illegal_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", o_illegal_cnt); end
    total++;
    if ({ctl, o_rd, o_rs1, o_rs2, o_pc} !== '0) begin
      bad++; $display("FAIL rst_bundle got=%h_%h_%h want=0", ctl, o_rd, o_pc);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise got=%0b want=1", o_ready); end
    total++; if (s_cnt !== 2'd0) begin bad++; $display("FAIL rst_sat_cnt got=%0d want=0", s_cnt); end
  endtask

  task automatic test_basic();
    @(negedge clk); i_valid = 1'b1; i_instr = 32'h0050_0093; i_pc = 32'h40; i_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0b want=1", o_valid); end
    total++;
    if (ctl !== {9'b001010000, 2'b00, 3'b000, 4'b0000}) begin
      bad++; $display("FAIL addi_ctl got=%b want=%b", ctl, {9'b001010000, 9'b0});
    end
    total++; if (o_rd !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d want=1", o_rd); end
    @(negedge clk); i_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%0b want=0", o_valid); end
  endtask

  task automatic test_illegal();
    @(negedge clk); i_valid = 1'b1; i_instr = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    total++; if (o_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%0b want=1", o_illegal); end
    total++; if (o_reg_write !== 1'b0) begin bad++; $display("FAIL ill_rw got=%0b want=0", o_reg_write); end
    total++; if (o_illegal_cnt !== 16'd1) begin bad++; $display("FAIL ill_cnt got=%0d want=1", o_illegal_cnt); end
    @(negedge clk); i_valid = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); s_valid = 1'b1;
      @(posedge clk); #1;
      if (k == 0) begin
        total++; if (s_cnt !== 2'd1) begin bad++; $display("FAIL sat_first got=%0d want=1", s_cnt); end
      end
    end
    total++; if (s_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d want=3", s_cnt); end
    @(negedge clk); s_valid = 1'b0;
  endtask

  // Streams one instruction per cycle with i_ready high; each lands in the output the next edge.
  task automatic test_decode();
    logic [31:0] ins [17];
    logic [17:0] exp [17];
    logic [17:0] msk [17];
    logic [4:0]  rd  [17];
    localparam logic [17:0] ALL = '1;
    localparam logic [17:0] ILLM = {9'b111100111, 9'b0};
    localparam logic [17:0] ILLV = {9'b000000001, 9'b0};
    ins[0]  = 32'h0050_0093; exp[0]  = {9'b001010000, 2'b00, 3'b000, 4'b0000}; rd[0]  = 5'd1;
    ins[1]  = 32'h0010_8133; exp[1]  = {9'b001000000, 2'b00, 3'b000, 4'b0000}; rd[1]  = 5'd2;
    ins[2]  = 32'h4020_81B3; exp[2]  = {9'b001000000, 2'b00, 3'b000, 4'b0001}; rd[2]  = 5'd3;
    ins[3]  = 32'h0000_A283; exp[3]  = {9'b001010000, 2'b01, 3'b000, 4'b0000}; rd[3]  = 5'd5;
    ins[4]  = 32'h0020_A023; exp[4]  = {9'b000110000, 2'b00, 3'b001, 4'b0000}; rd[4]  = 5'd0;
    ins[5]  = 32'h0020_8063; exp[5]  = {9'b010000000, 2'b00, 3'b010, 4'b0001}; rd[5]  = 5'd0;
    ins[6]  = 32'h0000_00EF; exp[6]  = {9'b101000000, 2'b10, 3'b011, 4'b0000}; rd[6]  = 5'd1;
    ins[7]  = 32'h0000_80E7; exp[7]  = {9'b001011000, 2'b00, 3'b000, 4'b0000}; rd[7]  = 5'd1;
    ins[8]  = 32'h0000_10B7; exp[8]  = {9'b001010000, 2'b00, 3'b100, 4'b0000}; rd[8]  = 5'd1;
    ins[9]  = 32'h0000_0097; exp[9]  = {9'b001010000, 2'b11, 3'b100, 4'b0000}; rd[9]  = 5'd1;
    ins[10] = 32'h0000_000F; exp[10] = {9'b000000100, 2'b00, 3'b000, 4'b0000}; rd[10] = 5'd0;
    ins[11] = 32'h4030_D093; exp[11] = {9'b001010000, 2'b00, 3'b000, 4'b0111}; rd[11] = 5'd1;
    ins[12] = 32'h0000_0073; exp[12] = {9'b001010000, 2'b00, 3'b000, 4'b0000}; rd[12] = 5'd0;
    ins[13] = 32'h4020_9033; exp[13] = ILLV; rd[13] = 5'd0;
    ins[14] = 32'h0000_0001; exp[14] = ILLV; rd[14] = 5'd0;
    ins[15] = 32'h4010_9093; exp[15] = ILLV; rd[15] = 5'd1;
    ins[16] = 32'h2000_8033; exp[16] = ILLV; rd[16] = 5'd0;
    for (int i = 0; i < 17; i++) msk[i] = (i >= 13) ? ILLM : ALL;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); i_valid = 1'b1; i_instr = ins[i]; i_pc = 32'h100 + 32'(4 * i);
      @(posedge clk); #1;
      total++;
      if (((ctl ^ exp[i]) & msk[i]) != '0 || o_rd !== rd[i] || o_valid !== 1'b1) begin
        bad++; $display("FAIL dec_%0d got=%b rd=%0d v=%0b want=%b rd=%0d", i, ctl, o_rd, o_valid, exp[i], rd[i]);
      end
    end
    @(negedge clk); i_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (o_illegal_cnt !== 16'd5) begin bad++; $display("FAIL dec_cnt got=%0d want=5", o_illegal_cnt); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); i_ready = 1'b0; i_valid = 1'b1; i_instr = 32'h0010_8133; i_pc = 32'h200;
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b1 || o_rd !== 5'd2 || o_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_one got v=%0b rd=%0d r=%0b want 1/2/1", o_valid, o_rd, o_ready);
    end
    @(negedge clk); i_instr = 32'h4020_81B3; i_pc = 32'h204;
    @(posedge clk); #1;
    total++; if (o_ready !== 1'b0 || o_rd !== 5'd2 || o_pc !== 32'h200) begin
      bad++; $display("FAIL b2b_full got r=%0b rd=%0d pc=%h want 0/2/200", o_ready, o_rd, o_pc);
    end
    @(negedge clk); i_instr = 32'h0000_A283; i_pc = 32'h208;
    @(posedge clk); #1;
    total++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_rd !== 5'd2 || o_rs1 !== 5'd1 ||
        ctl !== {9'b001000000, 9'b0} || o_pc !== 32'h200) begin
      bad++; $display("FAIL b2b_hold got r=%0b rd=%0d ctl=%b pc=%h want 0/2/add/200", o_ready, o_rd, ctl, o_pc);
    end
    @(negedge clk); i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (o_valid !== 1'b1 || o_rd !== 5'd3 || o_rs2 !== 5'd2 || o_pc !== 32'h204 ||
        o_alu_ctrl !== 4'b0001 || o_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_second got rd=%0d pc=%h alu=%b r=%0b want 3/204/0001/1", o_rd, o_pc, o_alu_ctrl, o_ready);
    end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b want=0", o_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk); i_ready = 1'b0; i_valid = 1'b1; i_instr = 32'h0050_0093;
    @(posedge clk);
    @(negedge clk); i_instr = 32'h0010_8133;
    @(posedge clk); #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL flush_fill got=%0b want=0", o_ready); end
    @(negedge clk); i_flush = 1'b1; i_instr = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_illegal_cnt !== 16'd5) begin
      bad++; $display("FAIL flush got v=%0b r=%0b cnt=%0d want 0/1/5", o_valid, o_ready, o_illegal_cnt);
    end
    @(negedge clk); i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
  endtask

  task automatic test_muldiv();
    @(negedge clk); i_valid = 1'b1; i_instr = 32'h0220_8033;
    @(posedge clk); #1;
`ifdef OSIRIS_DEC_MULDIV_EN
    total++;
    if (o_muldiv !== 1'b1 || o_illegal !== 1'b0 || o_alu_ctrl !== 4'b0000 || o_reg_write !== 1'b1) begin
      bad++; $display("FAIL mul got md=%0b il=%0b alu=%b rw=%0b want 1/0/0000/1", o_muldiv, o_illegal, o_alu_ctrl, o_reg_write);
    end
`else
    total++;
    if (o_muldiv !== 1'b0 || o_illegal !== 1'b1 || o_reg_write !== 1'b0) begin
      bad++; $display("FAIL mul got md=%0b il=%0b rw=%0b want 0/1/0", o_muldiv, o_illegal, o_reg_write);
    end
`endif
    @(negedge clk); i_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); i_valid = 1'b1; i_instr = 32'h0050_0093;
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%0b want=1", o_valid); end
    @(negedge clk); i_valid = 1'b0; i_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || o_illegal_cnt !== '0 || o_ready !== 1'b0) begin
      bad++; $display("FAIL rmid got v=%0b cnt=%0d r=%0b want 0/0/0", o_valid, o_illegal_cnt, o_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_decode();
    test_back_to_back();
    test_flush();
    test_muldiv();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
